// File: rtl/ii_capture_pkg.sv
// Shared constants and types for the OV7670 integral-image capture path.
package ii_capture_pkg;

    localparam int SRC_W        = 640;
    localparam int SRC_H        = 480;
    localparam int DECIM        = 4;
    localparam int II_W         = SRC_W / DECIM;
    localparam int II_H         = SRC_H / DECIM;
    localparam int ADDR_W       = 15;
    localparam int DATA_W       = 32;
    localparam int II_LAST_ADDR = II_W * II_H - 1;

    // Source counters saturate, so lines/frames longer than nominal cannot wrap.
    localparam int SRC_CNT_W    = 11;

    typedef logic [DATA_W-1:0] ii_word_t;
    typedef logic [ADDR_W-1:0] ii_addr_t;

endpackage

// File: rtl/ii_line_buffer.sv
// One output row of integral values; async read, sync write (read-before-write).
module ii_line_buffer
    import ii_capture_pkg::*;
#(
    parameter int DEPTH = II_W,
    parameter int WIDTH = DATA_W,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic [IDX_W-1:0] col,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_comb begin
        rd_data = mem[col];
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[col] <= wr_data;
        end
    end

endmodule

// File: rtl/ov7670_integral_image_capture.sv
// Decimates OV7670 luma and streams its integral image into a BRAM write port.
// Define II_FRAME_DONE_EN to add a frame_done pulse after the last write.
module ov7670_integral_image_capture #(
    parameter int SRC_W  = ii_capture_pkg::SRC_W,
    parameter int SRC_H  = ii_capture_pkg::SRC_H,
    parameter int DECIM  = ii_capture_pkg::DECIM,
    parameter int II_W   = SRC_W / DECIM,
    parameter int II_H   = SRC_H / DECIM,
    parameter int ADDR_W = ii_capture_pkg::ADDR_W,
    parameter int DATA_W = ii_capture_pkg::DATA_W
) (
    input  logic              ov7670_pclk,
    input  logic              rst,
    input  logic              ov7670_vsync,
    input  logic              ov7670_href,
    input  logic [7:0]        ov7670_data,
    output logic              we,
    output logic [ADDR_W-1:0] ii_address,
    output logic [DATA_W-1:0] ii_wrdata
`ifdef II_FRAME_DONE_EN
    ,
    output logic              frame_done
`endif
);

    localparam int CNT_W = ii_capture_pkg::SRC_CNT_W;
    localparam int COL_W = $clog2(II_W + 1);
    localparam int ROW_W = $clog2(II_H + 1);
    localparam int LB_W  = $clog2(II_W);

    logic              armed;
    logic              phase;
    logic              href_d;
    logic              first_row;
    logic [CNT_W-1:0]  src_col;
    logic [CNT_W-1:0]  src_row;
    logic [COL_W-1:0]  out_col;
    logic [ROW_W-1:0]  out_row;
    logic [DATA_W-1:0] rowsum;

    logic              sample;
    logic              row_on_grid;
    logic [DATA_W-1:0] rowsum_new;
    logic [DATA_W-1:0] prev_val;
    logic [DATA_W-1:0] ii_val;
    logic [ADDR_W-1:0] addr_next;

    ii_line_buffer #(
        .DEPTH (II_W),
        .WIDTH (DATA_W)
    ) u_line_buffer (
        .clk     (ov7670_pclk),
        .col     (out_col[LB_W-1:0]),
        .wr_en   (sample),
        .wr_data (ii_val),
        .rd_data (prev_val)
    );

    always_comb begin
        row_on_grid = (src_row % CNT_W'(DECIM)) == '0;
        sample      = armed && ov7670_href && !ov7670_vsync && !phase
                      && ((src_col % CNT_W'(DECIM)) == '0) && row_on_grid
                      && (out_col < COL_W'(II_W)) && (out_row < ROW_W'(II_H));
        rowsum_new  = rowsum + DATA_W'(ov7670_data);
        // Line-buffer RAM is never cleared; row 0 masks its stale contents instead.
        ii_val      = rowsum_new + (first_row ? '0 : prev_val);
        addr_next   = ADDR_W'(out_row) * ADDR_W'(II_W) + ADDR_W'(out_col);
    end

    always_ff @(posedge ov7670_pclk or negedge rst) begin
        if (!rst) begin
            we         <= 1'b0;
            ii_address <= '0;
            ii_wrdata  <= '0;
            armed      <= 1'b0;
            phase      <= 1'b0;
            href_d     <= 1'b0;
            first_row  <= 1'b0;
            src_col    <= '0;
            src_row    <= '0;
            out_col    <= '0;
            out_row    <= '0;
            rowsum     <= '0;
`ifdef II_FRAME_DONE_EN
            frame_done <= 1'b0;
`endif
        end else begin
            we     <= sample;
            href_d <= ov7670_href;
`ifdef II_FRAME_DONE_EN
            frame_done <= we && (ii_address == ADDR_W'(II_W * II_H - 1));
`endif
            if (sample) begin
                ii_address <= addr_next;
                ii_wrdata  <= ii_val;
            end

            if (ov7670_vsync) begin
                armed     <= 1'b1;
                first_row <= 1'b1;
                phase     <= 1'b0;
                src_col   <= '0;
                src_row   <= '0;
                out_col   <= '0;
                out_row   <= '0;
                rowsum    <= '0;
            end else if (ov7670_href) begin
                phase <= ~phase;
                if (!phase && (src_col != '1)) begin
                    src_col <= src_col + 1'b1;
                end
                if (sample) begin
                    rowsum  <= rowsum_new;
                    out_col <= out_col + 1'b1;
                end
            end else if (href_d) begin
                phase   <= 1'b0;
                src_col <= '0;
                if (src_row != '1) begin
                    src_row <= src_row + 1'b1;
                end
                if (row_on_grid && (out_row < ROW_W'(II_H))) begin
                    out_row   <= out_row + 1'b1;
                    out_col   <= '0;
                    rowsum    <= '0;
                    first_row <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ov7670_integral_image_capture.sv
// Scoreboard bench for ov7670_integral_image_capture on a reduced 64x32 frame.
module tb_ov7670_integral_image_capture;

    localparam int SW   = 64;
    localparam int SH   = 32;
    localparam int DEC  = 4;
    localparam int IW   = SW / DEC;
    localparam int IH   = SH / DEC;
    localparam int AW   = 15;
    localparam int DW   = 32;
    localparam int LAST = IW * IH - 1;

    logic          clk   = 1'b0;
    logic          rst   = 1'b0;
    logic          vsync = 1'b0;
    logic          href  = 1'b0;
    logic [7:0]    data  = 8'd0;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
`ifdef II_FRAME_DONE_EN
    logic          frame_done;
`endif

    ov7670_integral_image_capture #(
        .SRC_W  (SW),
        .SRC_H  (SH),
        .DECIM  (DEC),
        .II_W   (IW),
        .II_H   (IH),
        .ADDR_W (AW),
        .DATA_W (DW)
    ) dut (
        .ov7670_pclk  (clk),
        .rst          (rst),
        .ov7670_vsync (vsync),
        .ov7670_href  (href),
        .ov7670_data  (data),
        .we           (we),
        .ii_address   (addr),
        .ii_wrdata    (wdata)
`ifdef II_FRAME_DONE_EN
        ,
        .frame_done   (frame_done)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned addr;
        int unsigned data;
    } exp_t;

    int          tests = 0;
    int          fails = 0;
    int          writes = 0;
    exp_t        q[$];
    int unsigned obs [LAST+1];
    int unsigned dimg [IH][IW];
    int          last_addr = -2;
    int unsigned last_data = 0;
    bit          prev_last = 1'b0;

    task automatic check(input string name, input longint unsigned act, input longint unsigned req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every write strobe
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
`ifdef II_FRAME_DONE_EN
            if (prev_last || frame_done) check("frame_done", frame_done, prev_last);
            prev_last = we && (addr == AW'(LAST));
`endif
            if (we) begin
                writes++;
                check("addr_in_range", (addr <= AW'(LAST)), 1);
                if (addr <= AW'(LAST)) obs[addr] = wdata;
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_write: got addr=%0d data=%0d, expected no write (t=%0t)",
                             addr, wdata, $time);
                end else begin
                    e = q.pop_front();
                    check("ii_address", addr, e.addr);
                    check("ii_wrdata", wdata, e.data);
                end
                if ((int'(addr) == last_addr + 1) && (int'(addr) % IW != 0))
                    check("row_monotonic", (wdata >= last_data), 1);
                last_addr = int'(addr);
                last_data = wdata;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int unsigned ypix(input int md, input int row, input int col);
        if (md == 0) return 11;
        if (md == 1) return col / DEC;
        if (row % DEC == 0 && col % DEC == 0 && row / DEC < IH && col / DEC < IW)
            return dimg[row / DEC][col / DEC];
        return $urandom_range(0, 255);
    endfunction

    task automatic drive_line(input int md, input int row, input int px);
        href = 1'b1;
        for (int c = 0; c < px; c++) begin
            data = 8'(ypix(md, row, c));
            step();
            data = (md == 2) ? 8'($urandom_range(0, 255)) : 8'd200;
            step();
        end
        href = 1'b0;
        data = 8'd0;
        repeat (3) step();
    endtask

    task automatic fill_image(input int md);
        for (int r = 0; r < IH; r++)
            for (int c = 0; c < IW; c++)
                dimg[r][c] = (md == 0) ? 11 : (md == 1) ? c : $urandom_range(0, 255);
    endtask

    // Integral image as the plain 2-D rectangle sum of the decimated picture
    task automatic push_expected(input int rows);
        int unsigned s;
        for (int r = 0; r < rows; r++)
            for (int c = 0; c < IW; c++) begin
                s = 0;
                for (int rr = 0; rr <= r; rr++)
                    for (int cc = 0; cc <= c; cc++)
                        s += dimg[rr][cc];
                q.push_back('{addr: r * IW + c, data: s});
            end
    endtask

    task automatic vsync_pulse();
        vsync = 1'b1;
        repeat (3) step();
        vsync = 1'b0;
        repeat (2) step();
    endtask

    task automatic run_frame(input int md, input int lines, input int px);
        int rows;
        fill_image(md);
        for (int i = 0; i <= LAST; i++) obs[i] = 0;
        vsync_pulse();
        writes = 0;
        rows = (lines + DEC - 1) / DEC;
        if (rows > IH) rows = IH;
        push_expected(rows);
        for (int l = 0; l < lines; l++) drive_line(md, l, px);
        repeat (2) step();
        check("queue_drained", q.size(), 0);
    endtask

    initial begin : stimulus
        #12;
        check("reset_we", we, 0);
        check("reset_addr", addr, 0);
        check("reset_data", wdata, 0);
        step();
        rst = 1'b1;
        step();

        // Not armed yet: a full line must produce nothing
        writes = 0;
        drive_line(0, 0, SW);
        check("unarmed_writes", writes, 0);

        run_frame(0, SH, SW);
        check("const_write_count", writes, IW * IH);
        check("const_addr0", obs[0], 11);
        check("const_addr15", obs[15], 176);
        check("const_addr16", obs[16], 22);
        check("const_last", obs[LAST], 1408);

        run_frame(1, SH, SW);
        check("ramp_addr2", obs[2], 3);
        check("ramp_addr18", obs[18], 6);

        run_frame(2, SH, SW);
        check("rand_write_count", writes, IW * IH);

        // Mid-frame abort at line 13, then a fresh frame must restart at row 0
        run_frame(2, 13, SW);
        run_frame(2, SH, SW);
        check("after_abort_count", writes, IW * IH);

        // Asynchronous reset in the middle of a line
        fill_image(0);
        vsync_pulse();
        push_expected(3);
        for (int l = 0; l < 10; l++) drive_line(0, l, SW);
        href = 1'b1;
        for (int c = 0; c < 5; c++) begin
            data = 8'd11;
            step();
            data = 8'd200;
            step();
        end
        #2 rst = 1'b0;
        #1;
        check("midreset_we", we, 0);
        check("midreset_addr", addr, 0);
        href = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        writes = 0;
        for (int l = 0; l < 12; l++) drive_line(0, l, SW);
        check("post_reset_no_writes", writes, 0);
        run_frame(0, SH, SW);
        check("post_reset_addr0", obs[0], 11);

        // Oversized lines and frame
        run_frame(0, SH + 8, SW + 6);
        check("oversize_count", writes, IW * IH);
        check("oversize_last", obs[LAST], 1408);

        repeat (5) step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
